lsu_align: RTL and testbench
============================

# lsu_align

Load/store unit sitting directly upstream of the word-addressed data memory in the pipeline processor's MEM stage. It accepts one byte, halfword or word request at a time from the pipeline over a valid/ready handshake. It drives the memory's word-wide write port, using read-modify-write for sub-word stores because the memory has no byte enables. It returns lane-extracted, sign- or zero-extended load data and an error flag for misaligned or illegal accesses.

## Interface
- X_LEN, 32, data/address width; only 32 is supported.
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  unit can accept; high only in IDLE.
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  input  1  zero-extend loads when 1.
- req_addr_i  input  X_LEN  byte address.
- req_wdata_i  input  X_LEN  store data, right-justified.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_rdata_o  output  X_LEN  extended load data; 0 for stores and errors.
- rsp_err_o  output  1  misaligned or illegal-size request.
- mem_we_o  output  1  word write enable to data memory.
- mem_addr_o  output  X_LEN  byte address to memory, bits [1:0] forced to 00.
- mem_wdata_o  output  X_LEN  word write data.
- mem_rdata_i  input  X_LEN  combinational read data for mem_addr_o.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready_o=1. On req_valid_i, capture we, size, unsigned, addr and wdata into registers, then go to ACCESS.
- ACCESS: mem_addr_o = {addr_q[31:2],2'b00}.
  - Error request: no memory activity, err_q set, go to RESP.
  - Load: extract the lane from mem_rdata_i, extend it, register into rdata_q, go to RESP.
  - Word store: mem_we_o=1, mem_wdata_o=wdata_q, go to RESP.
  - Byte/half store: merge wdata_q low bits into mem_rdata_i at the lane, register into merge_q, go to WRITE.
- WRITE: mem_we_o=1, mem_wdata_o=merge_q, go to RESP.
- RESP: rsp_valid_o=1, rsp_rdata_o=rdata_q, rsp_err_o=err_q for exactly one cycle, then go to IDLE.
- Lane rules:
  - Byte lane = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16k+15:16k].
  - Signed loads replicate the lane MSB; unsigned loads zero-fill.
- Error: size 11 is always an error. Alignment errors are covered under Configuration.
- mem_we_o is a pure decode of state and registered type. It is never high in IDLE or RESP, and never high for loads or errors.

## Timing
- Reset values:
  - state=IDLE, so req_ready_o=1.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Latency from the accept edge to the rsp_valid_o cycle:
  - Load, word store, error: 2 cycles.
  - Byte/half store: 3 cycles.
- Throughput: one request per 3 cycles (load/word store) or 4 cycles (sub-word store). No back-to-back acceptance.
- req_ready_o is low from the cycle after accept through RESP. Input changes while busy are ignored.
- A request presented in the RESP cycle is not accepted; it is accepted in the following IDLE cycle.
- Reset mid-operation: on the reset edge, return to IDLE.
  - Pending WRITE is dropped: no mem_we_o pulse and no response.
  - Reset wins over a simultaneous req_valid_i.
- Stores commit at the rising edge that ends the mem_we_o cycle.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]≠00 is an error.
  - Errors give rsp_err_o=1, rsp_rdata_o=0, and no write.
- LSU_ALIGN_CHECK_EN undefined:
  - Half ignores addr[0]; word ignores addr[1:0]. The access is forced aligned.
  - Only size 11 raises rsp_err_o.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> exactly one mem_we_o pulse 1 cycle after accept; store response at accept+2; load rsp_rdata_o=0xDEADBEEF at accept+2.
- Memory word at 0x10 = 0x80FF7F01:
  - Signed byte load 0x13 -> 0xFFFFFF80.
  - Unsigned byte load 0x13 -> 0x00000080.
  - Signed half load 0x10 -> 0x00007F01.
- Word at 0x20 = 0x11223344, half store 0x0000BEEF to 0x22 -> mem_we_o only in WRITE, mem_wdata_o=0xBEEF3344, rsp_valid_o at accept+3, req_ready_o low for 3 cycles.
- Word load at 0x11:
  - With LSU_ALIGN_CHECK_EN: rsp_err_o=1, rsp_rdata_o=0, no mem_we_o.
  - Without: returns the word at 0x10, err=0.
  - size=11 in either build: err=1.
- Byte store to 0x31 with rst_i asserted in ACCESS cycle -> no mem_we_o pulse, no rsp_valid_o, req_ready_o=1 the cycle after the reset edge, word at 0x30 unchanged.
- req_valid_i held high with two queued loads -> second accepted only in the IDLE cycle after the first RESP; accept-to-accept spacing is 3 cycles.

Source files
------------

// File: rtl/lsu_align.sv
// lsu_align: MEM-stage load/store unit in front of a word-wide data memory without byte enables.
//   Sub-word stores use read-modify-write; loads return the lane, sign- or zero-extended.
//   Ports: clk_i/rst_i (sync, active-high); req_* valid/ready request (we, size, unsigned, addr, wdata);
//   rsp_* one-cycle response (rdata, err); mem_* word memory port (we, addr, wdata, combinational rdata).
//   Macro LSU_ALIGN_CHECK_EN: flag misaligned half/word as errors; when undefined they are forced aligned.
module lsu_align #(
  parameter int X_LEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [1:0]       req_size_i,
  input  logic             req_unsigned_i,
  input  logic [X_LEN-1:0] req_addr_i,
  input  logic [X_LEN-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [X_LEN-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_we_o,
  output logic [X_LEN-1:0] mem_addr_o,
  output logic [X_LEN-1:0] mem_wdata_o,
  input  logic [X_LEN-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic             we_q, uns_q, err_q, err_d;
  logic [1:0]       size_q;
  logic [X_LEN-1:0] addr_q, wdata_q, rdata_q, rdata_d, merge_q, merge_d, mask;
  logic [4:0]       sh;
  logic [7:0]       b;
  logic [15:0]      h;
  logic             bad;
`ifdef LSU_ALIGN_CHECK_EN
  assign bad = (size_q == 2'b11) | (size_q == 2'b01 & addr_q[0]) | (size_q == 2'b10 & |addr_q[1:0]);
`else
  assign bad = size_q == 2'b11;
`endif
  // Half lanes select on addr[1] only, so an unchecked misaligned half/word falls onto the aligned lane.
  assign sh   = size_q == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
  assign b    = 8'(mem_rdata_i >> sh);
  assign h    = 16'(mem_rdata_i >> sh);
  assign mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  always_comb begin
    err_d   = bad;
    merge_d = (mem_rdata_i & ~mask) | ((wdata_q << sh) & mask);
    rdata_d = (we_q | bad) ? '0 :
              size_q == 2'b00 ? {{24{~uns_q & b[7]}}, b} :
              size_q == 2'b01 ? {{16{~uns_q & h[15]}}, h} : mem_rdata_i;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = req_valid_i ? ACCESS : IDLE;
      ACCESS:  state_d = (we_q & ~bad & size_q != 2'b10) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state_q == ACCESS) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
        merge_q <= merge_d;
      end
    end
  end
  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign mem_addr_o  = {addr_q[X_LEN-1:2], 2'b00};
  assign mem_we_o    = (state_q == WRITE) | (state_q == ACCESS & we_q & ~bad & size_q == 2'b10);
  assign mem_wdata_o = ~mem_we_o ? '0 : state_q == WRITE ? merge_q : wdata_q;
endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed self-checking bench for lsu_align with a word memory model.
module tb_lsu_align;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        rsp_valid_o, rsp_err_o, mem_we_o;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_a = '0;
  logic [31:0] poke_d = '0;
  int          tests = 0, fails = 0;
  int          we_cnt, we_cyc, rsp_cyc, rdy_low, rsp_cnt, a1, a2, n;
  logic [31:0] we_data, rsp_data;
  logic        rsp_err, acc_rdy;
  lsu_align dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );
  always #5 clk_i = ~clk_i;
  assign mem_rdata_i = mem[mem_addr_o[7:2]];
  always @(posedge clk_i)
    if (poke_en) mem[poke_a] <= poke_d;
    else if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
  task automatic fail(input string tag);
    fails++;
    $error("FAIL %s", tag);
  endtask
  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    poke_a = a[7:2]; poke_d = d; poke_en = 1'b1;
    @(posedge clk_i); #1 poke_en = 1'b0;
  endtask
  task automatic run(input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd);
    req_we_i = we; req_size_i = sz; req_unsigned_i = un; req_addr_i = a; req_wdata_i = wd;
    req_valid_i = 1'b1;
    @(negedge clk_i); acc_rdy = req_ready_o;
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    we_cnt = 0; we_cyc = 0; rsp_cyc = 0; rdy_low = 0;
    we_data = '0; rsp_data = 'x; rsp_err = 1'bx;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (mem_we_o) begin we_cnt++; we_cyc = c; we_data = mem_wdata_o; end
      if (!req_ready_o) rdy_low++;
      if (rsp_valid_o && rsp_cyc == 0) begin rsp_cyc = c; rsp_data = rsp_rdata_o; rsp_err = rsp_err_o; end
      @(posedge clk_i); #1;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    tests++; if (req_ready_o !== 1'b1) fail("rst_ready");
    tests++; if (rsp_valid_o !== 1'b0) fail("rst_rsp_valid");
    tests++; if (rsp_rdata_o !== 32'h0) fail("rst_rdata");
    tests++; if (rsp_err_o !== 1'b0) fail("rst_err");
    tests++; if (mem_we_o !== 1'b0) fail("rst_mem_we");
    tests++; if (mem_addr_o !== 32'h0) fail("rst_mem_addr");
    tests++; if (mem_wdata_o !== 32'h0) fail("rst_mem_wdata");
    @(posedge clk_i); #1;
    run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    tests++; if (acc_rdy !== 1'b1) fail("sw_accept");
    tests++; if (we_cnt !== 1) fail("sw_we_cnt");
    tests++; if (we_cyc !== 1) fail("sw_we_cyc");
    tests++; if (we_data !== 32'hDEADBEEF) fail("sw_wdata");
    tests++; if (rsp_cyc !== 2) fail("sw_rsp_cyc");
    tests++; if (rsp_data !== 32'h0) fail("sw_rsp_data");
    tests++; if (rsp_err !== 1'b0) fail("sw_rsp_err");
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tests++; if (rsp_cyc !== 2) fail("lw_rsp_cyc");
    tests++; if (rsp_data !== 32'hDEADBEEF) fail("lw_data");
    tests++; if (we_cnt !== 0) fail("lw_no_we");
    tests++; if (rdy_low !== 2) fail("lw_ready_low");
    poke(32'h10, 32'h80FF7F01);
    run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    tests++; if (rsp_data !== 32'hFFFFFF80) fail("lb_s_13");
    run(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    tests++; if (rsp_data !== 32'h00000080) fail("lbu_13");
    run(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    tests++; if (rsp_data !== 32'h0000007F) fail("lb_s_11");
    run(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    tests++; if (rsp_data !== 32'h00007F01) fail("lh_s_10");
    run(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    tests++; if (rsp_data !== 32'hFFFF80FF) fail("lh_s_12");
    run(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    tests++; if (rsp_data !== 32'h000080FF) fail("lhu_12");
    poke(32'h20, 32'h11223344);
    run(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    tests++; if (we_cnt !== 1) fail("sh_we_cnt");
    tests++; if (we_cyc !== 2) fail("sh_we_cyc");
    tests++; if (we_data !== 32'hBEEF3344) fail("sh_wdata");
    tests++; if (rsp_cyc !== 3) fail("sh_rsp_cyc");
    tests++; if (rdy_low !== 3) fail("sh_ready_low");
    run(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AB);
    tests++; if (we_data !== 32'hBEEFAB44) fail("sb_wdata");
    tests++; if (mem[8] !== 32'hBEEFAB44) fail("sb_mem");
    run(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    tests++; if (rsp_err !== 1'b1) fail("lw_mis_err");
    tests++; if (rsp_data !== 32'h0) fail("lw_mis_data");
`else
    tests++; if (rsp_err !== 1'b0) fail("lw_mis_err");
    tests++; if (rsp_data !== 32'h80FF7F01) fail("lw_mis_data");
`endif
    tests++; if (we_cnt !== 0) fail("lw_mis_no_we");
    run(1'b1, 2'b01, 1'b0, 32'h23, 32'h00001234);
`ifdef LSU_ALIGN_CHECK_EN
    tests++; if (rsp_err !== 1'b1) fail("sh_mis_err");
    tests++; if (we_cnt !== 0) fail("sh_mis_we");
    tests++; if (mem[8] !== 32'hBEEFAB44) fail("sh_mis_mem");
`else
    tests++; if (rsp_err !== 1'b0) fail("sh_mis_err");
    tests++; if (we_cnt !== 1) fail("sh_mis_we");
    tests++; if (mem[8] !== 32'h1234AB44) fail("sh_mis_mem");
`endif
    run(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    tests++; if (rsp_err !== 1'b1) fail("ill_ld_err");
    tests++; if (rsp_data !== 32'h0) fail("ill_ld_data");
    tests++; if (rsp_cyc !== 2) fail("ill_ld_rsp_cyc");
    run(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
    tests++; if (rsp_err !== 1'b1) fail("ill_st_err");
    tests++; if (we_cnt !== 0) fail("ill_st_we");
    tests++; if (mem[4] !== 32'h80FF7F01) fail("ill_st_mem");
    poke(32'h30, 32'hCAFEF00D);
    req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h31; req_wdata_i = 32'h55; req_valid_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1 rst_i = 1'b1;
    we_cnt = 0; rsp_cnt = 0;
    @(negedge clk_i);
    if (mem_we_o) we_cnt++;
    if (rsp_valid_o) rsp_cnt++;
    @(posedge clk_i); #1 rst_i = 1'b0; req_valid_i = 1'b0;
    @(negedge clk_i);
    tests++; if (req_ready_o !== 1'b1) fail("rst_mid_ready");
    repeat (4) begin
      if (mem_we_o) we_cnt++;
      if (rsp_valid_o) rsp_cnt++;
      @(posedge clk_i); @(negedge clk_i);
    end
    tests++; if (we_cnt !== 0) fail("rst_mid_we");
    tests++; if (rsp_cnt !== 0) fail("rst_mid_rsp");
    tests++; if (mem[12] !== 32'hCAFEF00D) fail("rst_mid_mem");
    @(posedge clk_i); #1;
    req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h10; req_valid_i = 1'b1;
    a1 = -1; a2 = -1; n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        if (n == 0) a1 = c;
        else if (n == 1) a2 = c;
        n++;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    tests++; if (a1 !== 0) fail("b2b_first");
    tests++; if (a2 - a1 !== 3) fail("b2b_spacing");
    repeat (4) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
